// File: rtl/hd_sched_pkg.sv
// Shared types and sizing helpers for the HD encoding tile scheduler.
package hd_sched_pkg;

  // Scheduler state encoding, kept as plain constants for legacy tool flows.
  typedef logic [2:0] sched_state_t;

  localparam sched_state_t IDLE  = 3'd0;
  localparam sched_state_t CLEAR = 3'd1;
  localparam sched_state_t ISSUE = 3'd2;
  localparam sched_state_t WAIT  = 3'd3;
  localparam sched_state_t EMIT  = 3'd4;
  localparam sched_state_t DONE  = 3'd5;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  function automatic int unsigned num_tiles(input int unsigned dhv_size,
                                            input int unsigned m_size);
    return ceil_div(dhv_size, m_size);
  endfunction

  function automatic int unsigned num_chunks(input int unsigned div_size,
                                             input int unsigned n_size);
    return ceil_div(div_size, n_size);
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/tile_chunk_counter.sv
// Nested tile/chunk index counter for the encode tile scheduler.
// Chunk steps inside a tile; stepping the tile rewinds the chunk. Neither wraps.
module tile_chunk_counter
  import hd_sched_pkg::*;
#(
  parameter int unsigned NUM_TILES  = 3,
  parameter int unsigned NUM_CHUNKS = 2,
  parameter int unsigned TILE_W     = idx_width(NUM_TILES),
  parameter int unsigned CHUNK_W    = idx_width(NUM_CHUNKS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc_chunk,
  input  logic               inc_tile,
  output logic [TILE_W-1:0]  tile_idx,
  output logic [CHUNK_W-1:0] chunk_idx,
  output logic               last_tile,
  output logic               last_chunk
);

  assign last_tile  = (tile_idx == TILE_W'(NUM_TILES - 1));
  assign last_chunk = (chunk_idx == CHUNK_W'(NUM_CHUNKS - 1));

  // Index update: clear wins, then tile step (rewinds chunk), then chunk step.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      tile_idx  <= '0;
      chunk_idx <= '0;
    end else if (inc_tile) begin
      if (!last_tile) begin
        tile_idx  <= tile_idx + TILE_W'(1);
        chunk_idx <= '0;
      end
    end else if (inc_chunk) begin
      if (!last_chunk) begin
        chunk_idx <= chunk_idx + CHUNK_W'(1);
      end
    end
  end

endmodule

// File: rtl/encode_tile_scheduler.sv
// Encode tile scheduler: walks output tiles and feature chunks, sequences the
// encoding MAC through clear/start/done, and hands each finished tile downstream.
// Optional feature: define SCHED_PERF_CNT_EN to enable the perf_stall backpressure counter.
module encode_tile_scheduler
  import hd_sched_pkg::*;
#(
  parameter int unsigned DHV_SIZE   = 4000,
  parameter int unsigned DIV_SIZE   = 512,
  parameter int unsigned N_SIZE     = 16,
  parameter int unsigned M_SIZE     = 16,
  parameter int unsigned DIM_WIDTH  = 16,
  localparam int unsigned NUM_TILES  = num_tiles(DHV_SIZE, M_SIZE),
  localparam int unsigned NUM_CHUNKS = num_chunks(DIV_SIZE, N_SIZE),
  localparam int unsigned TILE_W     = idx_width(NUM_TILES),
  localparam int unsigned CHUNK_W    = idx_width(NUM_CHUNKS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [TILE_W-1:0]           tile_idx,
  output logic [CHUNK_W-1:0]          chunk_idx,
  output logic                        mac_clear,
  output logic                        mac_start,
  input  logic                        mac_done,
  input  logic [M_SIZE*DIM_WIDTH-1:0] mac_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [M_SIZE*DIM_WIDTH-1:0] out_tile,
  output logic [TILE_W-1:0]           out_tile_idx,
  output logic [M_SIZE-1:0]           out_mask,
  output logic [31:0]                 perf_stall
);

  sched_state_t state_q, state_d;

  logic cnt_clr;
  logic inc_chunk;
  logic inc_tile;
  logic capture;
  logic last_tile;
  logic last_chunk;
  logic [M_SIZE-1:0] mask_d;

  tile_chunk_counter #(
    .NUM_TILES  (NUM_TILES),
    .NUM_CHUNKS (NUM_CHUNKS),
    .TILE_W     (TILE_W),
    .CHUNK_W    (CHUNK_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .clr        (cnt_clr),
    .inc_chunk  (inc_chunk),
    .inc_tile   (inc_tile),
    .tile_idx   (tile_idx),
    .chunk_idx  (chunk_idx),
    .last_tile  (last_tile),
    .last_chunk (last_chunk)
  );

  // Next-state and counter control; mac_done is only honoured in WAIT.
  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    inc_chunk = 1'b0;
    inc_tile  = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mac_done) begin
          if (!last_chunk) begin
            inc_chunk = 1'b1;
            state_d   = ISSUE;
          end else begin
            capture = 1'b1;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (!last_tile) begin
            inc_tile = 1'b1;
            state_d  = CLEAR;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts straight to IDLE without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lanes past the hypervector end are masked; only the last tile can have any.
  always_comb begin
    mask_d = '0;
    for (int unsigned i = 0; i < M_SIZE; i++) begin
      mask_d[i] = ((32'(tile_idx) * M_SIZE) + i) < DHV_SIZE;
    end
  end

  // Result capture on the final chunk's mac_done; held through EMIT backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_tile     <= '0;
      out_tile_idx <= '0;
      out_mask     <= '0;
    end else if (capture) begin
      out_tile     <= mac_out;
      out_tile_idx <= tile_idx;
      out_mask     <= mask_d;
    end
  end

  assign busy      = (state_q == CLEAR) || (state_q == ISSUE) || (state_q == WAIT) ||
                     (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign mac_clear = (state_q == CLEAR);
  assign mac_start = (state_q == ISSUE);
  assign out_valid = (state_q == EMIT);

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of backpressured EMIT cycles, restarted per accepted run.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if ((state_q == EMIT) && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall = stall_q;
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_encode_tile_scheduler.sv
// Directed bench for encode_tile_scheduler: 3 tiles x 2 chunks, 3-cycle MAC model.
module tb_encode_tile_scheduler;

  localparam int unsigned DHV = 40;
  localparam int unsigned DIV = 32;
  localparam int unsigned NS  = 16;
  localparam int unsigned MS  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned NT  = 3;
  localparam int unsigned NC  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic mac_done = 1'b0;
  logic out_ready = 1'b1;
  logic busy, done, mac_clear, mac_start, out_valid;
  logic [1:0] tile_idx, out_tile_idx;
  logic [0:0] chunk_idx;
  logic [MS*DW-1:0] mac_out, out_tile;
  logic [MS-1:0] out_mask;
  logic [31:0] perf_stall;

  always #5 clk = ~clk;

  encode_tile_scheduler #(
    .DHV_SIZE  (DHV),
    .DIV_SIZE  (DIV),
    .N_SIZE    (NS),
    .M_SIZE    (MS),
    .DIM_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .tile_idx     (tile_idx),
    .chunk_idx    (chunk_idx),
    .mac_clear    (mac_clear),
    .mac_start    (mac_start),
    .mac_done     (mac_done),
    .mac_out      (mac_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_tile     (out_tile),
    .out_tile_idx (out_tile_idx),
    .out_mask     (out_mask),
    .perf_stall   (perf_stall)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference data: each (tile, chunk) pass adds a known per-lane contribution.
  function automatic logic [15:0] contrib(input int t, input int c, input int i);
    return 16'(t * 256 + c * 16 + i + 1);
  endfunction

  function automatic logic [255:0] exp_tile(input int t);
    logic [255:0] r = '0;
    for (int i = 0; i < int'(MS); i++) begin
      logic [15:0] s = '0;
      for (int c = 0; c < int'(NC); c++) s = s + contrib(t, c, i);
      r[i*16 +: 16] = s;
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_mask(input int t);
    logic [15:0] m = '0;
    for (int i = 0; i < int'(MS); i++) m[i] = (t * int'(MS) + i) < int'(DHV);
    return m;
  endfunction

  // MAC environment: 3-cycle latency, optional spurious done pulses.
  int mac_cnt = 0;
  logic [255:0] mac_acc = '0;
  logic [255:0] mac_pend = '0;
  bit spur_issue = 0;
  bit spur_emit = 0;
  assign mac_out = mac_acc;

  always @(negedge clk) begin
    mac_done = 1'b0;
    if (reset) begin
      mac_cnt = 0;
      mac_acc = '0;
    end else begin
      if (mac_clear) mac_acc = '0;
      if (mac_cnt > 0) begin
        mac_cnt--;
        if (mac_cnt == 0) begin
          for (int i = 0; i < int'(MS); i++)
            mac_acc[i*16 +: 16] = mac_acc[i*16 +: 16] + mac_pend[i*16 +: 16];
          mac_done = 1'b1;
        end
      end
      if (mac_start) begin
        mac_cnt = 3;
        for (int i = 0; i < int'(MS); i++)
          mac_pend[i*16 +: 16] = contrib(int'(tile_idx), int'(chunk_idx), i);
        if (spur_issue) mac_done = 1'b1;
      end
      if (out_valid && spur_emit) mac_done = 1'b1;
    end
  end

  // Scoreboard counters for the current run.
  int n_start, n_clear, n_emit, n_done, n_stall;
  logic [15:0] lane0_seen [NT];
  logic [15:0] mask_seen [NT];

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (mac_clear) begin
        check("clear_after_handshake", n_clear, n_emit);
        check("busy_in_clear", busy, 1'b1);
        n_clear++;
      end
      if (mac_start) begin
        check("busy_in_issue", busy, 1'b1);
        if (n_start < int'(NT * NC)) begin
          check("start_tile", tile_idx, n_start / int'(NC));
          check("start_chunk", chunk_idx, n_start % int'(NC));
          check("start_after_clear", n_clear, n_start / int'(NC) + 1);
        end else begin
          check("mac_start_count", n_start + 1, NT * NC);
        end
        n_start++;
      end
      if (out_valid) begin
        check("busy_in_emit", busy, 1'b1);
        if (n_emit < int'(NT)) begin
          check("out_tile_idx", out_tile_idx, n_emit);
          check("out_tile", out_tile, exp_tile(n_emit));
          check("out_mask", out_mask, exp_mask(n_emit));
          check("chunks_before_emit", n_start, (n_emit + 1) * int'(NC));
          if (out_ready) begin
            lane0_seen[n_emit] = out_tile[15:0];
            mask_seen[n_emit] = out_mask;
            n_emit++;
          end else begin
            n_stall++;
          end
        end else begin
          check("emit_count", n_emit + 1, NT);
        end
      end
      if (done) begin
        check("done_after_last_tile", n_emit, NT);
        check("busy_low_at_done", busy, 1'b0);
        n_done++;
      end
    end
  end

  task automatic clear_counters();
    n_start = 0; n_clear = 0; n_emit = 0; n_done = 0; n_stall = 0;
    for (int i = 0; i < int'(NT); i++) begin
      lane0_seen[i] = '0;
      mask_seen[i] = '0;
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {busy, done, tile_idx, chunk_idx, mac_clear, mac_start, out_valid,
                             out_tile_idx, out_mask, perf_stall}, '0);
    check({name, "_out_tile"}, out_tile, '0);
  endtask

  // One run: optional backpressure on one tile, start glitches, or reset abort in WAIT of tile 1.
  task automatic run(input int stall_tile, input bit glitch, input bit abort,
                     output bit finished);
    int stall_left = 5;
    bit glitched = 0;
    bit in_wait;
    finished = 0;
    clear_counters();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      in_wait = busy && !mac_clear && !mac_start && !out_valid;
      if (out_valid && (int'(out_tile_idx) == stall_tile) && (stall_left > 0)) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (glitch && in_wait && !glitched) begin
        start = 1'b1;
        glitched = 1;
      end
      if (abort && in_wait && (tile_idx == 2'd1)) begin
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check_all_zero("abort_reset");
        return;
      end
      if (done) begin
        finished = 1;
        if (glitch) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        break;
      end
    end
  endtask

  task automatic end_checks(input int exp_stall);
    repeat (8) @(posedge clk);
    #1;
    check("clear_count", n_clear, NT);
    check("start_count", n_start, NT * NC);
    check("emit_count_total", n_emit, NT);
    check("done_count", n_done, 1);
    check("busy_idle", busy, 1'b0);
    check("stall_cycles", n_stall, exp_stall);
`ifdef SCHED_PERF_CNT_EN
    check("perf_stall", perf_stall, exp_stall);
`else
    check("perf_stall", perf_stall, 0);
`endif
  endtask

  bit fin;

  initial begin
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_state");
    reset = 1'b0;
    clear_counters();

    // Basic run and last-tile mask.
    run(-1, 0, 0, fin);
    check("run1_finished", fin, 1'b1);
    end_checks(0);
    check("mask_tile0", mask_seen[0], 16'hFFFF);
    check("mask_tile1", mask_seen[1], 16'hFFFF);
    check("mask_tile2", mask_seen[2], 16'h00FF);
    check("tile0_lane0", lane0_seen[0], 16'd18);
    check("tile2_lane0", lane0_seen[2], 16'd1042);

    // Backpressure on tile 1 for 5 cycles.
    run(1, 0, 0, fin);
    check("run3_finished", fin, 1'b1);
    end_checks(5);

    // Start glitches in WAIT and DONE are ignored.
    run(-1, 1, 0, fin);
    check("run4_finished", fin, 1'b1);
    end_checks(0);

    // Reset abort in WAIT of tile 1, then a clean run.
    run(-1, 0, 1, fin);
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", n_done, 0);
    check("abort_idle_busy", busy, 1'b0);
    check("abort_no_clear", mac_clear, 1'b0);
    run(-1, 0, 0, fin);
    check("run5_finished", fin, 1'b1);
    end_checks(0);

    // Spurious mac_done in ISSUE and EMIT.
    spur_issue = 1;
    spur_emit = 1;
    run(-1, 0, 0, fin);
    check("run6_finished", fin, 1'b1);
    end_checks(0);
    spur_issue = 0;
    spur_emit = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
